// File: rtl/regfile_port_ctrl_if.sv
// Bundle of the writeback, operand-fetch and register-file signals handled by
// regfile_port_ctrl. master = pipeline/register-file side, slave = controller.
interface regfile_port_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              wr0_valid;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr0_ready;
  logic              wr1_valid;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              wr1_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addra;
  logic [ADDR_W-1:0] rd_addrb;
  logic              rd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_a;
  logic [DATA_W-1:0] rsp_b;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rw;
  logic [ADDR_W-1:0] rf_ra;
  logic [ADDR_W-1:0] rf_rb;
  logic [DATA_W-1:0] rf_din;
  logic [DATA_W-1:0] rf_douta;
  logic [DATA_W-1:0] rf_doutb;
  logic              init_done;

  modport master (
    output wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
    output rd_valid, rd_addra, rd_addrb, rf_douta, rf_doutb,
    input  wr0_ready, wr1_ready, rd_ready, rsp_valid, rsp_a, rsp_b,
    input  rf_we, rf_rw, rf_ra, rf_rb, rf_din, init_done
  );

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data, wr1_valid, wr1_addr, wr1_data,
    input  rd_valid, rd_addra, rd_addrb, rf_douta, rf_doutb,
    output wr0_ready, wr1_ready, rd_ready, rsp_valid, rsp_a, rsp_b,
    output rf_we, rf_rw, rf_ra, rf_rb, rf_din, init_done
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Single-port register file controller: zero-clearing sweep after reset, then
// round-robin between two writers and a starvation-bounded dual reader.
module regfile_port_ctrl #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  regfile_port_ctrl_if.slave bus
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sc;
  logic [3:0]        starve;
  logic              prefer_wr1;
  logic [ADDR_W-1:0] ra_q, rb_q;
  logic              rsp_valid_q;
  logic              init_done_q;

  logic              grant_w0, grant_w1, grant_rd;
  logic              we;
  logic [ADDR_W-1:0] rw;
  logic [DATA_W-1:0] din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_w0  = 1'b0;
    grant_w1  = 1'b0;
    grant_rd  = 1'b0;
    we        = 1'b0;
    rw        = bus.wr0_addr;
    din       = bus.wr0_data;
    unique case (state)
      INIT: begin
        // rst_n gate keeps the array untouched while reset is held.
        we  = rst_n;
        rw  = sc;
        din = '0;
        if (sc == '1) state_nxt = RUN;
      end
      RUN: begin
        if (bus.rd_valid && starve == WAIT_LIM)   grant_rd = 1'b1;
        else if (bus.wr0_valid && bus.wr1_valid) begin
          if (prefer_wr1) grant_w1 = 1'b1;
          else            grant_w0 = 1'b1;
        end
        else if (bus.wr0_valid)                  grant_w0 = 1'b1;
        else if (bus.wr1_valid)                  grant_w1 = 1'b1;
        else if (bus.rd_valid)                   grant_rd = 1'b1;
        if (grant_w1) begin
          rw  = bus.wr1_addr;
          din = bus.wr1_data;
        end
        // Register 0 writes are accepted but never reach the array.
        we = (grant_w0 && bus.wr0_addr != '0) || (grant_w1 && bus.wr1_addr != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc          <= '0;
      starve      <= '0;
      prefer_wr1  <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      rsp_valid_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      if (state == INIT) begin
        sc <= sc + 1'b1;
        if (sc == '1) init_done_q <= 1'b1;
      end
      rsp_valid_q <= grant_rd;
      if (grant_rd) begin
        ra_q <= bus.rd_addra;
        rb_q <= bus.rd_addrb;
      end
      if (grant_rd || !bus.rd_valid) starve <= '0;
      else if (starve != WAIT_LIM)   starve <= starve + 1'b1;
      if (grant_w0)      prefer_wr1 <= 1'b1;
      else if (grant_w1) prefer_wr1 <= 1'b0;
    end
  end

  assign bus.wr0_ready = grant_w0;
  assign bus.wr1_ready = grant_w1;
  assign bus.rd_ready  = grant_rd;
  assign bus.rf_we     = we;
  assign bus.rf_rw     = rw;
  assign bus.rf_din    = din;
  assign bus.rf_ra     = grant_rd ? bus.rd_addra : ra_q;
  assign bus.rf_rb     = grant_rd ? bus.rd_addrb : rb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_a     = bus.rf_douta;
  assign bus.rsp_b     = bus.rf_doutb;
  assign bus.init_done = init_done_q;

endmodule
